// File: rtl/bean_pkg.sv
// Shared encodings and constants for the bean obstacle scheduler.
package bean_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } game_state_t;

    typedef enum logic {
        BEAN_FLOOR  = 1'b0,
        BEAN_FLYING = 1'b1
    } bean_type_t;

    localparam int SCREEN_W = 640;
    localparam int COORD_W  = 10;

endpackage

// File: rtl/bean_lfsr.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), loads SEED on synchronous reset.
module bean_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] rnd
);

    logic [15:0] state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SEED;
        end else begin
            state <= {1'b0, state[15:1]} ^ (state[0] ? 16'hB400 : 16'h0000);
        end
    end

    // Only the low byte is consumed by the spawner.
    assign rnd = state[7:0];

endmodule

// File: rtl/bean_spawn_ctrl.sv
// Goose-run obstacle scheduler: scrolls, retires and spawns up to three beans
// and runs the IDLE/RUN/OVER game FSM.
module bean_spawn_ctrl
    import bean_pkg::*;
#(
    parameter int          NUM_SLOTS         = 3,
    parameter int          SPAWN_X           = 700,
    parameter int          MIN_GAP           = 160,
    parameter int          SPEED_INIT        = 2,
    parameter int          SPEED_MAX         = 8,
    parameter int          SPEED_STEP_FRAMES = 600,
    parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_tick,
    input  logic                         start,
    input  logic                         check_hit,
    output logic [NUM_SLOTS*COORD_W-1:0] bean_x,
    output logic [NUM_SLOTS-1:0]         bean_type,
    output logic [NUM_SLOTS-1:0]         bean_valid,
    output logic [3:0]                   speed,
    output logic [1:0]                   game_state,
    output logic                         score_tick
);

    localparam int SLOT_W = 2;
    localparam int GAP_W  = 9;
    localparam int FCNT_W = 10;

    game_state_t          state_q, state_d;
    logic [7:0]           rnd;
    logic                 do_tick, do_clear;

    logic [COORD_W-1:0]   x_q  [NUM_SLOTS];
    logic [COORD_W-1:0]   x_mv [NUM_SLOTS];
    logic [COORD_W-1:0]   x_d  [NUM_SLOTS];
    bean_type_t           t_q  [NUM_SLOTS];
    bean_type_t           t_d  [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] v_q, v_mv, v_d;
    logic [SLOT_W-1:0]    last_q, last_d, free_idx;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [FCNT_W-1:0]    fcnt_q;
    logic [3:0]           speed_q;
    logic                 retire, free_found, spawn_ok;
    logic [COORD_W:0]     reach;

    bean_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .rnd   (rnd)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)     state_d = RUN;
            RUN:     if (check_hit) state_d = OVER;
            OVER:    if (start)     state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // A hit suppresses the frame update on the same edge.
    always_comb begin
        do_tick    = (state_q == RUN) && frame_tick && !check_hit;
        do_clear   = (state_q == OVER) && start;
        game_state = state_q;
    end

    always_comb begin
        retire     = 1'b0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            x_mv[i] = x_q[i];
            v_mv[i] = v_q[i];
            if (v_q[i]) begin
                if (x_q[i] <= COORD_W'(speed_q)) begin
                    x_mv[i] = '0;
                    v_mv[i] = 1'b0;
                    retire  = 1'b1;
                end else begin
                    x_mv[i] = x_q[i] - COORD_W'(speed_q);
                end
            end
        end
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!v_mv[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
        end
        // A retired last bean leaves nothing to space against.
        reach    = (COORD_W+1)'(x_mv[last_q]) + (COORD_W+1)'(gap_q);
        spawn_ok = !(|v_mv) || !v_mv[last_q] || (reach <= (COORD_W+1)'(SPAWN_X));

        x_d    = x_mv;
        v_d    = v_mv;
        t_d    = t_q;
        last_d = last_q;
        gap_d  = gap_q;
        if (spawn_ok && free_found) begin
            x_d[free_idx] = COORD_W'(SPAWN_X);
            v_d[free_idx] = 1'b1;
            t_d[free_idx] = bean_type_t'(rnd[0]);
            last_d        = free_idx;
            gap_d         = GAP_W'(MIN_GAP) + GAP_W'(rnd[7:1]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                x_q[i] <= '0;
                t_q[i] <= BEAN_FLOOR;
            end
            v_q        <= '0;
            last_q     <= '0;
            gap_q      <= GAP_W'(MIN_GAP);
            fcnt_q     <= '0;
            speed_q    <= 4'(SPEED_INIT);
            score_tick <= 1'b0;
        end else begin
            score_tick <= do_tick && retire;
            if (do_tick) begin
                for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                    x_q[i] <= x_d[i];
                    t_q[i] <= t_d[i];
                end
                v_q    <= v_d;
                last_q <= last_d;
                gap_q  <= gap_d;
                if (fcnt_q == FCNT_W'(SPEED_STEP_FRAMES - 1)) begin
                    fcnt_q <= '0;
                    if (speed_q < 4'(SPEED_MAX)) speed_q <= speed_q + 4'd1;
                end else begin
                    fcnt_q <= fcnt_q + FCNT_W'(1);
                end
            end else if (do_clear) begin
                for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                    x_q[i] <= '0;
                end
                v_q     <= '0;
                fcnt_q  <= '0;
                speed_q <= 4'(SPEED_INIT);
            end
        end
    end

    always_comb begin
        bean_x    = '0;
        bean_type = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            bean_x[COORD_W*i +: COORD_W] = x_q[i];
            bean_type[i]                 = t_q[i];
        end
        bean_valid = v_q;
        speed      = speed_q;
    end

endmodule

// File: doc/bean_spawn_ctrl.md
Name: bean_spawn_ctrl

Overview:
- Obstacle scheduler for the goose-run game. Owns up to 3 bean slots: horizontal position, type (floor/flying) and valid flag.
- Scrolls the slots once per frame tick and retires beans that leave the screen.
- Spawns new beans using pseudo-random gaps and types, ramps scroll speed over time, and runs the IDLE/RUN/OVER game FSM.
- Sits between the frame timing source and the bean renderer. The renderer reads slot state and returns the collision flag.

Parameters:
- NUM_SLOTS, 3: number of bean slots. Fixed at 3 in this revision.
- SPAWN_X, 700: x coordinate assigned to a newly spawned bean.
- MIN_GAP, 160: minimum pixel gap between consecutive spawns. Must exceed SPEED_MAX*2.
- SPEED_INIT, 2: scroll step in pixels per frame after reset or restart.
- SPEED_MAX, 8: speed saturation value.
- SPEED_STEP_FRAMES, 600: RUN frames between speed increments.
- LFSR_SEED, 16'hACE1: LFSR value loaded on reset. Must be nonzero.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- frame_tick, input, 1: one-cycle pulse, once per video frame.
- start, input, 1: level input. Starts a game from IDLE and clears the game from OVER.
- check_hit, input, 1: collision flag from the renderer, sampled every cycle.
- bean_x, output, 30: slot positions. Slot i occupies bits [10i+9:10i], unsigned pixels.
- bean_type, output, 3: per-slot type. 0 = floor, 1 = flying.
- bean_valid, output, 3: per-slot occupied flag.
- speed, output, 4: current scroll step.
- game_state, output, 2: 0 = IDLE, 1 = RUN, 2 = OVER.
- score_tick, output, 1: one-cycle pulse when a bean retires.

Behaviour:
- Reset (synchronous, wins over everything):
  - game_state = IDLE; bean_valid = 0; bean_x = 0; bean_type = 0.
  - speed = SPEED_INIT; frame counter = 0; score_tick = 0; LFSR = LFSR_SEED.
- All outputs are registered. Effects of an input appear on the clock edge after it is sampled.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every clock in all states, so the sequence depends on player timing.
- FSM:
  - IDLE: start=1 goes to RUN. Slots stay empty.
  - RUN: check_hit=1 goes to OVER on the next edge. Hit has priority over a frame_tick in the same cycle: no move, spawn or retire happens on that edge.
  - OVER: slots, speed and frame counter are frozen so the renderer keeps drawing the crash. start=1 goes to IDLE, clears all valid bits and x, and sets speed = SPEED_INIT and frame counter = 0.
  - A start held continuously therefore passes OVER -> IDLE -> RUN on consecutive edges. This is accepted behaviour.
- RUN, on frame_tick with no hit, processed in this order:
  1. Move/retire for each valid slot:
     - If x <= speed: clear valid, set x = 0, pulse score_tick.
     - Otherwise x = x - speed.
     - No unsigned underflow is ever produced.
     - MIN_GAP guarantees at most one retire per tick. score_tick is one cycle wide.
  2. Spawn check, on the post-move positions:
     - Spawn if no slot is valid, or if bean_x[last] + next_gap <= SPAWN_X. Compute this sum at 11 bits.
     - The new bean takes the lowest-index free slot: x = SPAWN_X, type = lfsr[0], valid = 1.
     - Record last = that slot and next_gap = MIN_GAP + lfsr[7:1], giving a range of 160..287.
     - At most one spawn per tick.
     - If no slot is free, the spawn is deferred to the next tick with no error.
     - If the last-spawned slot has already retired, treat the condition as true.
  3. Speed ramp:
     - The frame counter increments each tick.
     - When it reaches SPEED_STEP_FRAMES-1 it clears and speed increments, saturating at SPEED_MAX.
- frame_tick outside RUN has no effect.

Decomposition:
- Package bean_pkg holds:
  - game-state encodings IDLE/RUN/OVER;
  - bean type encodings BEAN_FLOOR/BEAN_FLYING;
  - the SCREEN_W = 640 constant;
  - the 10-bit coordinate width.
- Sub-module bean_lfsr: 16-bit Galois LFSR with seed parameter and synchronous reset load. This lets the bench force the sequence.
- Slot update, spawn logic and FSM live in bean_spawn_ctrl.

Test Plan:
1. Assert reset for 2 cycles -> game_state=0, bean_valid=3'b000, bean_x=0, speed=2, score_tick=0.
2. start=1 for 1 cycle, then frame_tick -> bean_valid=3'b001, bean_x[9:0]=700. Next tick -> x=698, and no second spawn until slot0 x <= 700-next_gap, with next_gap observed in 160..287.
3. Force slot0 to x=2 at speed 2, then frame_tick -> valid[0]=0, x=0, score_tick high for exactly 1 cycle. With all slots full, the spawn is deferred and the next free slot is filled on the following tick.
4. check_hit and frame_tick in the same cycle while in RUN -> game_state=2, positions unchanged. Further ticks change nothing. start -> game_state=0, all valid cleared, speed=2.
5. Run 600 ticks -> speed=3. Run 600*6 more ticks -> speed=8, and speed stays 8 after another 600 ticks.
6. Assert reset during RUN with 3 valid beans -> next edge shows the full reset state regardless of frame_tick, check_hit or start.
